// File: rtl/rd_data_checker.sv
// rd_data_checker: streaming Avalon-MM read-data checker for the memory tester.
// Compare commands are queued in a small FIFO. Each readdata beat is checked
// against a replicated PTRN_W-wide pattern, either fixed or LFSR-generated,
// under a per-beat byte mask. The block records the first error (address, beat
// data), keeps a saturating count of erroneous beats, and flags orphan beats.
// Optional build macro: RD_DATA_CHECKER_TIMEOUT_EN adds timeout_o and a
// watchdog that aborts a CHECK stalled for TIMEOUT cycles.
module rd_data_checker #(
  parameter int AMM_DATA_W = 128,
  parameter int ADDR_W     = 32,
  parameter int BURST_W    = 11,
  parameter int PTRN_W     = 8,
  parameter int CMD_DEPTH  = 4,
  parameter int ERR_CNT_W  = 16,
  parameter int TIMEOUT    = 1024,
  localparam int ADDR_B_W  = $clog2(AMM_DATA_W / 8)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_W-1:0]     cmd_start_addr_i,
  input  logic [ADDR_B_W-1:0]   cmd_start_off_i,
  input  logic [ADDR_B_W-1:0]   cmd_end_off_i,
  input  logic [BURST_W-2:0]    cmd_words_count_i,
  input  logic                  cmd_data_mode_i,
  input  logic [PTRN_W-1:0]     cmd_data_ptrn_i,
  input  logic                  readdatavalid_i,
  input  logic [AMM_DATA_W-1:0] readdata_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [ADDR_W-1:0]     err_addr_o,
  output logic [AMM_DATA_W-1:0] err_data_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o,
  output logic                  orphan_o
`ifdef RD_DATA_CHECKER_TIMEOUT_EN
  ,
  output logic                  timeout_o
`endif
);

  localparam int NBYTES = AMM_DATA_W / 8;
  localparam int NLANES = AMM_DATA_W / PTRN_W;
  localparam int WA_W   = ADDR_W - ADDR_B_W;
  localparam int WC_W   = BURST_W - 1;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [WA_W-1:0]     waddr;
    logic [ADDR_B_W-1:0] start_off;
    logic [ADDR_B_W-1:0] end_off;
    logic [WC_W-1:0]     wc;
    logic                mode;
    logic [PTRN_W-1:0]   ptrn;
  } cmd_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  // Command handshake: a command is taken on a rising clk_i edge where both
  // cmd_valid_i and cmd_ready_o are high; cmd_ready_o only depends on FIFO
  // occupancy, so a producer may hold valid high and push every cycle.
  logic push, pop;
  logic fifo_empty, fifo_full;
  cmd_t cmd_in, head;

  cmd_t              fifo_mem_q [CMD_DEPTH];
  cmd_t              fifo_mem_d [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  state_t            state_q, state_d;
  cmd_t              act_q, act_d;
  logic [WC_W-1:0]   beat_q, beat_d;
  logic [PTRN_W-1:0] lfsr_q, lfsr_d;

  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
  logic [AMM_DATA_W-1:0] err_data_q, err_data_d;
  logic                  orphan_q, orphan_d;

  logic                  in_idle, beat_acc, orphan_beat, cmd_done, beat_err;
  logic                  first_beat, last_beat, lfsr_fb, abort;
  cmd_t                  cur_cmd;
  logic [WC_W-1:0]       cur_beat;
  logic [PTRN_W-1:0]     head_seed, cur_lfsr, lfsr_adv, lane_val;
  logic [AMM_DATA_W-1:0] exp_data;
  logic [NBYTES-1:0]     err_vec;
  logic [ADDR_B_W-1:0]   err_byte;

  // Byte-offset bits of the start address select nothing: beats are word aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_start_addr_i[ADDR_B_W-1:0];

  assign cmd_in = '{waddr:     cmd_start_addr_i[ADDR_W-1:ADDR_B_W],
                    start_off: cmd_start_off_i,
                    end_off:   cmd_end_off_i,
                    wc:        cmd_words_count_i,
                    mode:      cmd_data_mode_i,
                    ptrn:      cmd_data_ptrn_i};

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(CMD_DEPTH));
  assign push       = cmd_valid_i && cmd_ready_o;
  assign head       = fifo_mem_q[rd_ptr_q];
  // An all-zero seed would lock the LFSR, so it is replaced by all ones.
  assign head_seed  = (head.ptrn == '0) ? '1 : head.ptrn;

  // In IDLE with a queued command the head is checked in the same cycle it pops.
  assign in_idle     = (state_q == ST_IDLE);
  assign cur_cmd     = in_idle ? head : act_q;
  assign cur_beat    = in_idle ? '0 : beat_q;
  assign cur_lfsr    = in_idle ? head_seed : lfsr_q;
  assign beat_acc    = readdatavalid_i && (!in_idle || !fifo_empty);
  assign orphan_beat = readdatavalid_i && in_idle && fifo_empty;
  assign first_beat  = (cur_beat == '0);
  assign last_beat   = (cur_beat == cur_cmd.wc);
  assign cmd_done    = beat_acc && last_beat;
  assign pop         = !fifo_empty && (in_idle || cmd_done);

  // Fibonacci LFSR, shifting toward the MSB with the tap XOR fed into bit 0.
  if (PTRN_W == 32) begin : g_fb32
    assign lfsr_fb = cur_lfsr[31] ^ cur_lfsr[21] ^ cur_lfsr[1] ^ cur_lfsr[0];
  end else if (PTRN_W == 16) begin : g_fb16
    assign lfsr_fb = cur_lfsr[15] ^ cur_lfsr[14] ^ cur_lfsr[12] ^ cur_lfsr[3];
  end else begin : g_fb8
    assign lfsr_fb = cur_lfsr[7] ^ cur_lfsr[5] ^ cur_lfsr[4] ^ cur_lfsr[3];
  end
  assign lfsr_adv = {cur_lfsr[PTRN_W-2:0], lfsr_fb};
  assign lane_val = cur_cmd.mode ? cur_lfsr : cur_cmd.ptrn;
  assign exp_data = {NLANES{lane_val}};

`ifdef RD_DATA_CHECKER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;

  // Watchdog: counts stalled CHECK cycles; a beat restarts it.
  always_comb begin
    to_cnt_d  = '0;
    abort     = 1'b0;
    timeout_d = clear_i ? 1'b0 : timeout_q;
    if (!in_idle && !beat_acc) begin
      if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
        abort     = 1'b1;
        timeout_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign abort = 1'b0;
`endif

  // Command FIFO pointer and storage update.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: chain straight into the next command when one is queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty && !cmd_done) state_d = ST_CHECK;
      ST_CHECK: if (abort || (cmd_done && fifo_empty)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cmd_ready_o = !fifo_full;
    busy_o      = (state_q == ST_CHECK) || !fifo_empty;
    err_o       = err_q;
    err_cnt_o   = err_cnt_q;
    err_addr_o  = err_addr_q;
    err_data_o  = err_data_q;
    orphan_o    = orphan_q;
`ifdef RD_DATA_CHECKER_TIMEOUT_EN
    timeout_o   = timeout_q;
`endif
  end

  // Active command, beat index and LFSR state.
  always_comb begin
    act_d  = act_q;
    beat_d = beat_q;
    lfsr_d = lfsr_q;
    if (pop) begin
      act_d = head;
      if (in_idle && beat_acc) begin
        beat_d = WC_W'(1);
        lfsr_d = lfsr_adv;
      end else begin
        beat_d = '0;
        lfsr_d = head_seed;
      end
    end else if (!in_idle && beat_acc) begin
      beat_d = beat_q + WC_W'(1);
      lfsr_d = lfsr_adv;
    end
  end

  // Masked byte compare; lowest failing byte is the reported lane.
  always_comb begin
    err_vec  = '0;
    err_byte = '0;
    for (int b = 0; b < NBYTES; b++) begin
      err_vec[b] = (!first_beat || (ADDR_B_W'(b) >= cur_cmd.start_off)) &&
                   (!last_beat  || (ADDR_B_W'(b) <= cur_cmd.end_off)) &&
                   (readdata_i[8*b +: 8] != exp_data[8*b +: 8]);
    end
    for (int b = NBYTES - 1; b >= 0; b--) begin
      if (err_vec[b]) err_byte = ADDR_B_W'(b);
    end
  end
  assign beat_err = beat_acc && (err_vec != '0);

  // Error status: a same-cycle error overrides clear_i.
  always_comb begin
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    orphan_d   = orphan_q;
    if (clear_i) begin
      err_d      = 1'b0;
      err_cnt_d  = '0;
      err_addr_d = '0;
      err_data_d = '0;
      orphan_d   = 1'b0;
    end
    if (beat_err) begin
      err_d = 1'b1;
      if (err_cnt_d != '1) err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
      if (!err_q || clear_i) begin
        err_addr_d = {cur_cmd.waddr + WA_W'(cur_beat), err_byte};
        err_data_d = readdata_i;
      end
    end
    if (orphan_beat) orphan_d = 1'b1;
  end

  // Datapath and status registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < CMD_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      act_q      <= '0;
      beat_q     <= '0;
      lfsr_q     <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
      orphan_q   <= 1'b0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      beat_q     <= beat_d;
      lfsr_q     <= lfsr_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
      orphan_q   <= orphan_d;
    end
  end

endmodule
